// File: rtl/aes_round_seq.sv
// rtl/aes_round_seq.sv - iterative AES-128 round sequencer driving a shared round datapath and key-expansion step
module aes_round_seq #(
  parameter int         NR    = 10,
  parameter logic [7:0] RCON0 = 8'h01
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_pt,
  input  logic [127:0] in_key,
  input  logic         abort,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_ct,
  output logic [127:0] dp_state,
  output logic         dp_last,
  input  logic [127:0] dp_result,
  output logic [127:0] ks_key,
  output logic [7:0]   ks_rcon,
  input  logic [127:0] ks_next_key,
  output logic         busy,
  output logic [3:0]   round
);

  typedef enum logic [1:0] {IDLE, ROUND, DONE} fsm_t;

  localparam logic [3:0] LAST = 4'(NR);

  fsm_t         fsm;
  logic [127:0] state;
  logic [127:0] rkey;
  logic [7:0]   rcon;
  logic [7:0]   rcon_nx;

  function automatic logic [7:0] xtime(input logic [7:0] v);
    return {v[6:0], 1'b0} ^ (v[7] ? 8'h1b : 8'h00);
  endfunction

  assign rcon_nx  = xtime(rcon);
  assign out_ct   = state;
  assign dp_state = state;
  assign ks_key   = rkey;

  // ks_rcon and dp_last are registered copies that read zero outside ROUND
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm       <= IDLE;
      state     <= '0;
      rkey      <= '0;
      rcon      <= RCON0;
      round     <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      dp_last   <= 1'b0;
      ks_rcon   <= '0;
    end else begin
      case (fsm)
        IDLE: begin
          if (in_valid && in_ready) begin
            state    <= in_pt ^ in_key;
            rkey     <= in_key;
            rcon     <= RCON0;
            ks_rcon  <= RCON0;
            round    <= 4'd1;
            dp_last  <= (LAST == 4'd1);
            busy     <= 1'b1;
            in_ready <= 1'b0;
            fsm      <= ROUND;
          end
        end
        ROUND: begin
          if (abort) begin
            fsm      <= IDLE;
            round    <= '0;
            busy     <= 1'b0;
            dp_last  <= 1'b0;
            ks_rcon  <= '0;
            in_ready <= 1'b1;
          end else begin
            state <= dp_result ^ ks_next_key;
            rkey  <= ks_next_key;
            rcon  <= rcon_nx;
            if (round == LAST) begin
              round     <= '0;
              busy      <= 1'b0;
              dp_last   <= 1'b0;
              ks_rcon   <= '0;
              out_valid <= 1'b1;
              fsm       <= DONE;
            end else begin
              round   <= round + 4'd1;
              ks_rcon <= rcon_nx;
              dp_last <= (round + 4'd1 == LAST);
            end
          end
        end
        DONE: begin
          // abort takes priority: a block cancelled here is never delivered
          if (abort || out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            fsm       <= IDLE;
          end
        end
        default: begin
          fsm       <= IDLE;
          round     <= '0;
          busy      <= 1'b0;
          dp_last   <= 1'b0;
          ks_rcon   <= '0;
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_aes_round_seq.sv
// tb/tb_aes_round_seq.sv - scoreboard bench for aes_round_seq with a behavioural AES round and key-schedule model
module tb_aes_round_seq;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_pt;
  logic [127:0] in_key;
  logic         abort;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_ct;
  logic [127:0] dp_state;
  logic         dp_last;
  logic [127:0] dp_result;
  logic [127:0] ks_key;
  logic [7:0]   ks_rcon;
  logic [127:0] ks_next_key;
  logic         busy;
  logic [3:0]   round;

  aes_round_seq dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_pt(in_pt), .in_key(in_key), .abort(abort), .out_valid(out_valid),
    .out_ready(out_ready), .out_ct(out_ct), .dp_state(dp_state), .dp_last(dp_last),
    .dp_result(dp_result), .ks_key(ks_key), .ks_rcon(ks_rcon),
    .ks_next_key(ks_next_key), .busy(busy), .round(round)
  );

  always #5 clk = ~clk;

  localparam logic [127:0] PT1  = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] KEY1 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] CT1  = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] PT2  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] KEY2 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] CT2  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  logic [7:0] rc_tab [10] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};

  int n_checks = 0;
  int n_errors = 0;
  int n_deliv  = 0;
  int cyc      = 0;
  int last_acc = 0;
  logic prev_ov = 1'b0;
  logic [127:0] cur_exp;
  logic [127:0] exp_q [$];

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    logic [7:0] y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
      y = y >> 1;
    end
    return p;
  endfunction

  // S-box from the field inverse (a^254) followed by the affine transform
  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] p = a;
    logic [7:0] r = 8'h01;
    logic [7:0] b;
    for (int i = 1; i < 8; i++) begin
      p = gmul(p, p);
      r = gmul(r, p);
    end
    b = r;
    return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [127:0] model_round(input logic [127:0] s, input logic last);
    logic [7:0] sb [16];
    logic [7:0] sr [16];
    logic [7:0] a0, a1, a2, a3;
    logic [127:0] o;
    for (int i = 0; i < 16; i++) sb[i] = sbox(s[127-8*i -: 8]);
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++) sr[r+4*c] = sb[r+4*((c+r)%4)];
    for (int c = 0; c < 4; c++) begin
      a0 = sr[4*c]; a1 = sr[4*c+1]; a2 = sr[4*c+2]; a3 = sr[4*c+3];
      if (last) begin
        o[127-32*c -: 32] = {a0, a1, a2, a3};
      end else begin
        o[127-32*c -: 32] = {gmul(a0, 8'h02) ^ gmul(a1, 8'h03) ^ a2 ^ a3,
                             a0 ^ gmul(a1, 8'h02) ^ gmul(a2, 8'h03) ^ a3,
                             a0 ^ a1 ^ gmul(a2, 8'h02) ^ gmul(a3, 8'h03),
                             gmul(a0, 8'h03) ^ a1 ^ a2 ^ gmul(a3, 8'h02)};
      end
    end
    return o;
  endfunction

  function automatic logic [127:0] model_ks(input logic [127:0] k, input logic [7:0] rc);
    logic [31:0] w0, w1, w2, w3, t;
    w0 = k[127:96]; w1 = k[95:64]; w2 = k[63:32]; w3 = k[31:0];
    t  = {sbox(w3[23:16]), sbox(w3[15:8]), sbox(w3[7:0]), sbox(w3[31:24])} ^ {rc, 24'h0};
    w0 = w0 ^ t; w1 = w1 ^ w0; w2 = w2 ^ w1; w3 = w3 ^ w2;
    return {w0, w1, w2, w3};
  endfunction

  always_comb begin
    dp_result   = model_round(dp_state, dp_last);
    ks_next_key = model_ks(ks_key, ks_rcon);
  end

  always @(negedge clk) begin
    cyc++;
    if (rst_n) begin
      check("in_ready_excl", {127'b0, in_ready & (busy | out_valid)}, 128'd0);
      if (out_valid && !prev_ov) check("latency", cyc - last_acc, 11);
      if (in_valid && in_ready) begin
        exp_q.push_back(cur_exp);
        last_acc = cyc;
      end
      if (abort && (busy || out_valid)) begin
        if (exp_q.size() > 0) void'(exp_q.pop_front());
      end else if (out_valid && out_ready) begin
        n_deliv++;
        if (exp_q.size() == 0) check("ct_unexpected", out_ct, 128'd0);
        else check("ct", out_ct, exp_q.pop_front());
      end
      prev_ov = out_valid;
    end else begin
      prev_ov = 1'b0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [127:0] pt, input logic [127:0] key,
                      input logic [127:0] exp, input bit keep);
    logic acc = 1'b0;
    in_pt = pt; in_key = key; cur_exp = exp; in_valid = 1'b1;
    for (int i = 0; i < 40 && !acc; i++) begin
      acc = in_ready;
      tick();
    end
    check("accept", {127'b0, acc}, 128'd1);
    if (!keep) in_valid = 1'b0;
  endtask

  task automatic wait_out();
    for (int i = 0; i < 40 && !out_valid; i++) tick();
    check("wait_out", {127'b0, out_valid}, 128'd1);
  endtask

  task automatic wait_round(input int r);
    for (int i = 0; i < 40 && round != 4'(r); i++) tick();
    check("wait_round", {124'b0, round}, 128'(r));
  endtask

  logic [127:0] held;
  int t1, t2, t3, d0;

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_pt = '0; in_key = '0;
    abort = 1'b0; out_ready = 1'b1; cur_exp = '0;
    tick(); tick();
    check("rst_in_ready", {127'b0, in_ready}, 128'd1);
    check("rst_out_valid", {127'b0, out_valid}, 128'd0);
    check("rst_busy", {127'b0, busy}, 128'd0);
    check("rst_round", {124'b0, round}, 128'd0);
    check("rst_ks_rcon", {120'b0, ks_rcon}, 128'd0);
    check("rst_out_ct", out_ct, 128'd0);
    rst_n = 1'b1;
    tick();

    // FIPS-197 App.B
    send(PT1, KEY1, CT1, 1'b0);
    wait_out();
    tick();
    check("t1_idle", {126'b0, in_ready, out_valid}, 128'd2);

    // FIPS-197 App.C.1 with per-round rcon / dp_last trace
    send(PT2, KEY2, CT2, 1'b0);
    for (int r = 1; r <= 10; r++) begin
      check("t2_round", {124'b0, round}, 128'(r));
      check("t2_rcon", {120'b0, ks_rcon}, {120'b0, rc_tab[r-1]});
      check("t2_last", {126'b0, dp_last, busy}, {126'b0, r == 10, 1'b1});
      tick();
    end
    check("t2_done", {120'b0, ks_rcon, round, busy, out_valid, in_ready, dp_last}, 128'h4);
    tick();

    // backpressure
    out_ready = 1'b0;
    send(PT1, KEY1, CT1, 1'b0);
    wait_out();
    held = out_ct;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("t3_hold_ct", out_ct, held);
      check("t3_hold_flags", {125'b0, out_valid, in_ready, busy}, 128'd4);
    end
    out_ready = 1'b1;
    tick();
    check("t3_release", {126'b0, in_ready, out_valid}, 128'd2);
    send(PT2, KEY2, CT2, 1'b0);
    wait_out();
    tick();

    // abort in round 4
    d0 = n_deliv;
    send(PT2, KEY2, CT2, 1'b0);
    wait_round(4);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("t4_abort", {120'b0, round, busy, out_valid, in_ready, 1'b0}, 128'h2);
    for (int i = 0; i < 15; i++) tick();
    check("t4_no_out", 128'(n_deliv - d0), 128'd0);
    send(PT1, KEY1, CT1, 1'b0);
    wait_out();
    tick();

    // reset mid-block
    d0 = n_deliv;
    send(PT1, KEY1, CT1, 1'b0);
    wait_round(6);
    rst_n = 1'b0;
    #1;
    check("t5_rst", {120'b0, round, busy, out_valid, in_ready, dp_last}, 128'h2);
    check("t5_rst_rcon", {120'b0, ks_rcon}, 128'd0);
    exp_q.delete();
    tick(); tick();
    rst_n = 1'b1;
    tick();
    check("t5_in_ready", {127'b0, in_ready}, 128'd1);
    for (int i = 0; i < 15; i++) tick();
    check("t5_no_out", 128'(n_deliv - d0), 128'd0);

    // back-to-back with in_valid held high
    send(PT1, KEY1, CT1, 1'b1);
    t1 = cyc;
    send(PT2, KEY2, CT2, 1'b1);
    t2 = cyc;
    send(PT1, KEY1, CT1, 1'b0);
    t3 = cyc;
    check("t6_gap1", 128'(t2 - t1), 128'd12);
    check("t6_gap2", 128'(t3 - t2), 128'd12);
    for (int i = 0; i < 40 && exp_q.size() > 0; i++) tick();
    check("drain", 128'(exp_q.size()), 128'd0);
    check("deliveries", 128'(n_deliv), 128'd8);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
